// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider sequencer.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, divide-by-zero quotient pattern and the
// iteration counter width helper.
package div_pkg;

    // State encoding, kept as named constants so waveform decoders and
    // any future debug taps share one source of truth.
    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_PREP_ENC = 3'd1;
    localparam logic [2:0] ST_ITER_ENC = 3'd2;
    localparam logic [2:0] ST_FIX_ENC  = 3'd3;
    localparam logic [2:0] ST_DONE_ENC = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE_ENC,
        PREP = ST_PREP_ENC,
        ITER = ST_ITER_ENC,
        FIX  = ST_FIX_ENC,
        DONE = ST_DONE_ENC
    } div_state_t;

    // Quotient reported on divide-by-zero: all ones. Stored wide and sliced
    // down to the instance width, so WIDTH may not exceed DBZ_MAX_WIDTH.
    localparam int DBZ_MAX_WIDTH = 128;
    localparam logic [DBZ_MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

    // Width of the iteration counter, which has to reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between the execute stage and the divider.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
//
// master: execute/writeback side (drives request, kill, resp_ready)
// slave : divider side (drives req_ready, response, busy)
interface div_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signctl;
    logic             remainder_out;
    logic             kill;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] result;
    logic             dbz;
    logic             busy;

    modport master (
        output req_valid, a, b, signctl, remainder_out, kill, resp_ready,
        input  req_ready, resp_valid, result, dbz, busy
    );

    modport slave (
        input  req_valid, a, b, signctl, remainder_out, kill, resp_ready,
        output req_ready, resp_valid, result, dbz, busy
    );
endinterface

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift {rem,quo} left, subtract divisor if it fits.
// Latency: combinational.
// Backpressure: none.
//
// Ports: rem[W:0], quo[W-1:0], divisor[W-1:0] in; rem_nxt[W:0], quo_nxt[W-1:0] out.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] rem_sub;
    logic           fits;

    always_comb begin
        rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        // If rem's top bit was set, the true shifted value overflows rem_sh
        // and is certainly >= divisor; the modulo-2^(W+1) difference is
        // still exact because the true difference is below the divisor.
        fits    = rem[WIDTH] | (rem_sh >= {1'b0, divisor});
        rem_sub = rem_sh - {1'b0, divisor};
        rem_nxt = fits ? rem_sub : rem_sh;
        quo_nxt = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for the iterative integer divider: signed/unsigned, divide-by-zero, flush (kill).
// Latency: response valid WIDTH+3 edges after accept (accept edge counted as the first), 3 for divide-by-zero.
// Backpressure: req_ready only in IDLE; result/dbz held in DONE until resp_ready; one op in flight.
//
// Ports: clk, rst (sync, active-high), bus (div_seq_ctrl_if.slave):
//   req_valid/req_ready/a/b/signctl/remainder_out  request
//   kill                                           flush of the op in flight
//   resp_valid/resp_ready/result/dbz               response
//   busy                                           controller not idle
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    div_seq_ctrl_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] result_q;
    logic             dbz_q;

    // Operand registers. b_reg holds the raw divisor until PREP, then |b|.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             signctl_q;
    logic             rem_sel;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] rem_lo;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] fix_result;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (b_reg),
        .rem_nxt (step_rem),
        .quo_nxt (step_quo)
    );

    // Magnitudes of the latched operands. The most negative value maps to
    // itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        abs_a = (signctl_q && a_reg[WIDTH-1]) ? -a_reg : a_reg;
        abs_b = (signctl_q && b_reg[WIDTH-1]) ? -b_reg : b_reg;
    end

    // Sign fix-up and result selection, loaded into result_q in FIX.
    // Divide-by-zero also passes through FIX so result_q has one load point.
    always_comb begin
        rem_lo  = rem[WIDTH-1:0];
        quo_fix = neg_q ? -quo : quo;
        rem_fix = neg_r ? -rem_lo : rem_lo;
        if (dbz_q) begin
            fix_result = rem_sel ? a_reg : DBZ_QUOTIENT[WIDTH-1:0];
        end else begin
            fix_result = rem_sel ? rem_fix : quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            result_q     <= '0;
            dbz_q        <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            signctl_q    <= 1'b0;
            rem_sel      <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            rem          <= '0;
            quo          <= '0;
            count        <= '0;
        end else if (bus.kill) begin
            // In IDLE this only blocks a same-cycle accept; elsewhere it
            // abandons the operation without a response.
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_reg       <= bus.a;
                        b_reg       <= bus.b;
                        signctl_q   <= bus.signctl;
                        rem_sel     <= bus.remainder_out;
                        dbz_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= PREP;
                    end
                end
                PREP: begin
                    neg_q <= signctl_q & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    neg_r <= signctl_q & a_reg[WIDTH-1];
                    if (b_reg == '0) begin
                        dbz_q <= 1'b1;
                        state <= FIX;
                    end else begin
                        rem   <= '0;
                        quo   <= abs_a;
                        b_reg <= abs_b;
                        count <= '0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    rem   <= step_rem;
                    quo   <= step_quo;
                    count <= count + 1'b1;
                    if (count == LAST_CNT) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_q     <= fix_result;
                    resp_valid_q <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.busy       = busy_q;
    assign bus.result     = result_q;
    assign bus.dbz        = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl (WIDTH=32) with a response scoreboard.
// Latency: checks WIDTH+3 / 3 edge response latency from the accept edge.
// Backpressure: exercises resp_ready stalls, kill and mid-operation reset.
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic clk;
    logic rst;

    div_seq_ctrl_if #(.WIDTH(W)) bus ();

    div_seq_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected responses: {dbz, result}.
    logic [W:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                         input logic is, input logic ir);
        logic [W-1:0] ua, ub, q, r;
        if (ib == '0) return {1'b1, (ir ? ia : 32'hFFFF_FFFF)};
        ua = (is && ia[W-1]) ? -ia : ia;
        ub = (is && ib[W-1]) ? -ib : ib;
        q  = ua / ub;
        r  = ua % ub;
        if (is && (ia[W-1] ^ ib[W-1])) q = -q;
        if (is && ia[W-1]) r = -r;
        return {1'b0, (ir ? r : q)};
    endfunction

    // Present one request and return #1 after its accept edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic is, input logic ir);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_before_issue", bus.req_ready, 1);
        bus.a             = ia;
        bus.b             = ib;
        bus.signctl       = is;
        bus.remainder_out = ir;
        bus.req_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.a         = $urandom;
        bus.b         = $urandom;
    endtask

    // Wait for the response, check latency, hold it for 'stall' cycles,
    // compare against the scoreboard, then complete the handshake.
    task automatic collect(input string tag, input int lat_exp, input int stall);
        int n;
        logic [W:0] e;
        n = 1;
        while (!bus.resp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, n, lat_exp);
        chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_stall_valid"}, bus.resp_valid, 1);
            chk({tag, "_stall_result"}, bus.result, e[W-1:0]);
            chk({tag, "_stall_req_ready"}, bus.req_ready, 0);
            @(posedge clk);
            #1;
        end
        chk({tag, "_result"}, bus.result, e[W-1:0]);
        chk({tag, "_dbz"}, bus.dbz, e[W]);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk({tag, "_valid_drop"}, bus.resp_valid, 0);
        chk({tag, "_back_idle"}, bus.req_ready, 1);
    endtask

    task automatic op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic is, input logic ir, input logic [W:0] exp, input int stall);
        sb.push_back(exp);
        issue(ia, ib, is, ir);
        collect(tag, (ib == '0) ? 3 : W + 3, stall);
    endtask

    // Watch for a response that must never appear.
    task automatic expect_silence(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) seen = 1'b1;
        end
        chk({tag, "_no_resp"}, seen, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst               = 1'b1;
        bus.req_valid     = 1'b0;
        bus.a             = '0;
        bus.b             = '0;
        bus.signctl       = 1'b0;
        bus.remainder_out = 1'b0;
        bus.kill          = 1'b0;
        bus.resp_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_dbz", bus.dbz, 0);
        rst = 1'b0;

        op("udiv_100_7", 32'd100, 32'd7, 1'b0, 1'b0, {1'b0, 32'd14}, 0);
        op("sdiv_m7_2_q", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, {1'b0, 32'hFFFF_FFFD}, 0);
        op("sdiv_m7_2_r", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, {1'b0, 32'hFFFF_FFFF}, 0);
        op("dbz_q", 32'h1234, 32'd0, 1'b0, 1'b0, {1'b1, 32'hFFFF_FFFF}, 0);
        op("dbz_r", 32'h1234, 32'd0, 1'b0, 1'b1, {1'b1, 32'h0000_1234}, 0);
        op("ovf_q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, {1'b0, 32'h8000_0000}, 0);
        op("ovf_r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, {1'b0, 32'h0000_0000}, 0);
        op("unsigned_big", 32'hFFFF_FFFF, 32'd16, 1'b0, 1'b0, {1'b0, 32'h0FFF_FFFF}, 0);
        op("stall10", 32'd1000, 32'd33, 1'b0, 1'b1, {1'b0, 32'd10}, 10);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i < 3) ? W'($urandom_range(1, 300)) : $urandom;
            op("rand", ra, rb, i[0], i[1], model(ra, rb, i[0], i[1]), 0);
        end

        // Kill while idle with a request present: the accept is suppressed.
        @(negedge clk);
        bus.a         = 32'd9;
        bus.b         = 32'd3;
        bus.req_valid = 1'b1;
        bus.kill      = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.kill      = 1'b0;
        chk("idle_kill_busy", bus.busy, 0);
        chk("idle_kill_req_ready", bus.req_ready, 1);
        expect_silence("idle_kill", 40);

        // Kill part-way through the iterations (count==10).
        issue(32'd12345, 32'd7, 1'b0, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        chk("iter_busy", bus.busy, 1);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        chk("kill_req_ready", bus.req_ready, 1);
        chk("kill_busy", bus.busy, 0);
        expect_silence("kill", 40);

        // Reset while the next operation sits in PREP.
        issue(32'd777, 32'd3, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_req_ready", bus.req_ready, 1);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_result", bus.result, 0);
        expect_silence("midrst", 40);

        op("after_flush", 32'd50, 32'd5, 1'b0, 1'b0, {1'b0, 32'd10}, 0);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
